// File: rtl/arbiter_rr_param_pkg.sv
// Shared types and helpers for the parametrised round-robin / fixed-priority arbiter.
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Index 0 means "no grant", so the encoding has to cover 0..n.
  function automatic int idx_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/arbiter_rr_param_if.sv
// Request/grant bundle between the request sources (master) and the arbiter (slave).
interface arbiter_rr_param_if #(parameter int N = 3) ();
  import arb_pkg::*;
  localparam int IW = idx_width(N);

  logic          rr_en;
  logic [N:1]    r;
  logic [N:1]    g;
  logic [IW-1:0] gnt_id;
  logic          busy;

  modport master (output rr_en, output r, input g, input gnt_id, input busy);
  modport slave  (input rr_en, input r, output g, output gnt_id, output busy);
endinterface

// File: rtl/arbiter_rr_param_prio_pick.sv
// Combinational rotating-priority picker: first set, non-excluded request at or after start.
// Zero latency; no flow control, the result is valid whenever any candidate remains.
module arb_prio_pick
  import arb_pkg::*;
#(
  parameter int N  = 3,
  parameter int IW = idx_width(N)
) (
  input  logic [N:1]    req,
  input  logic [IW-1:0] start,
  input  logic [N:1]    excl,
  output logic [N:1]    onehot,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [N:1]    masked;
  logic [IW-1:0] cand;

  assign masked = req & ~excl;

  // start is always 1..N; the search order wraps N back to 1.
  always_comb begin
    onehot = '0;
    idx    = '0;
    vld    = 1'b0;
    cand   = '0;
    for (int off = 0; off < N; off++) begin
      cand = IW'(((int'(start) - 1 + off) % N) + 1);
      if (!vld && masked[cand]) begin
        vld          = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/arbiter_rr_param.sv
// N-way registered arbiter with fixed/round-robin modes, grant locking and a hold limit.
// Grant appears one edge after the request; a busy holder only yields on drop or hold limit.
module arbiter_rr_param
  import arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               reset,
  arbiter_rr_param_if.slave bus
);
  localparam int              IW       = idx_width(N);
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [IW-1:0]   PTR_RST  = IW'(N);

  arb_state_t    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N:1]    g_q, g_d;

  logic [IW-1:0] start;
  logic [HW-1:0] hold_inc;
  logic [N:1]    pick_oh;
  logic [IW-1:0] pick_idx;
  logic          pick_vld;
  logic          holder_req;
  logic          others;
  logic          rotate;
  logic          rearb;

  assign start      = (bus.rr_en == MODE_RR) ?
                      ((ptr_q >= PTR_RST) ? IW'(1) : ptr_q + IW'(1)) : IW'(1);
  assign holder_req = |(bus.r & g_q);
  assign others     = |(bus.r & ~g_q);
  assign hold_inc   = (hold_q >= HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);
  assign rotate     = (bus.rr_en == MODE_RR) && others && (hold_q >= HOLD_MAX);

  // Excluding the current holder covers both forced rotation and holder drop.
  arb_prio_pick #(.N(N), .IW(IW)) u_pick (
    .req    (bus.r),
    .start  (start),
    .excl   (g_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .vld    (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    hold_d  = hold_q;
    g_d     = g_q;
    rearb   = 1'b0;

    if (state_q == GRANT && holder_req && !rotate) begin
      hold_d = hold_inc;
    end else begin
      rearb = 1'b1;
    end

    if (rearb) begin
      if (pick_vld) begin
        state_d = GRANT;
        g_d     = pick_oh;
        id_d    = pick_idx;
        ptr_d   = pick_idx;
        hold_d  = HW'(1);
      end else begin
        state_d = IDLE;
        g_d     = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= PTR_RST;
      id_q    <= '0;
      hold_q  <= '0;
      g_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      hold_q  <= hold_d;
      g_q     <= g_d;
    end
  end

  assign bus.g      = g_q;
  assign bus.gnt_id = id_q;
  assign bus.busy   = (state_q == GRANT);
endmodule

// File: tb/tb_arbiter_rr_param.sv
// Bench for arbiter_rr_param (N=3, MAX_HOLD=4): directed vector table, async-reset corner, random vs model.
module tb_arbiter_rr_param;
  import arb_pkg::*;

  localparam int N        = 3;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arbiter_rr_param_if #(.N(N)) bus ();

  arbiter_rr_param #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Reference state: holder index (0 = none), last granted index, consecutive-hold count.
  int m_holder;
  int m_ptr;
  int m_hold;

  function automatic logic [1:0] idx_of(input logic [3:1] v);
    for (int i = 1; i <= N; i++)
      if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic int first_req(input int req, input int from, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = ((from - 1 + k) % N) + 1;
      if (((req >> (i - 1)) & 1) == 1 && i != skip) return i;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_holder = 0;
    m_ptr    = N;
    m_hold   = 0;
  endtask

  task automatic model_step(input logic rr, input logic [3:1] rv);
    int  req, from, w;
    bit  keep;
    req  = int'(rv);
    from = rr ? (m_ptr % N) + 1 : 1;
    keep = 1'b0;
    if (m_holder != 0 && ((req >> (m_holder - 1)) & 1) == 1) begin
      bit others;
      others = (req & ~(1 << (m_holder - 1))) != 0;
      keep   = !(rr && others && m_hold >= MAX_HOLD);
    end
    if (keep) begin
      m_hold = (m_hold >= MAX_HOLD) ? MAX_HOLD : m_hold + 1;
    end else begin
      w = first_req(req, from, m_holder);
      if (w != 0) begin
        m_holder = w;
        m_hold   = 1;
        m_ptr    = w;
      end else begin
        m_holder = 0;
        m_hold   = 0;
      end
    end
  endtask

  function automatic logic [3:1] model_g();
    logic [3:1] v;
    v = '0;
    if (m_holder != 0) v[m_holder] = 1'b1;
    return v;
  endfunction

  task automatic check(input string nm, input logic [3:1] eg);
    logic [1:0] eid;
    logic       eb;
    eid = idx_of(eg);
    eb  = (eg != 3'b000);
    total++;
    if (bus.g !== eg || bus.gnt_id !== eid || bus.busy !== eb) begin
      bad++;
      $display("FAIL %s: got g=%b id=%0d busy=%b, want g=%b id=%0d busy=%b",
               nm, bus.g, bus.gnt_id, bus.busy, eg, eid, eb);
    end
  endtask

  task automatic apply(input logic rr, input logic [3:1] rv);
    bus.rr_en = rr;
    bus.r     = rv;
    @(posedge clk);
    model_step(rr, rv);
    #1;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("reset_clear", 3'b000);
    model_reset();
    #2 reset = 1'b0;
  endtask

  always @(negedge clk) begin
    total++;
    if (!$onehot0(bus.g) || bus.gnt_id !== idx_of(bus.g) || bus.busy !== (bus.g != 3'b000)) begin
      bad++;
      $display("FAIL onehot_id: got g=%b id=%0d busy=%b, want one-hot-or-zero g with matching id/busy",
               bus.g, bus.gnt_id, bus.busy);
    end
  end

  typedef struct {
    logic       pre_rst;
    logic       rr;
    logic [3:1] r;
    logic [3:1] exp_g;
    int         reps;
    string      nm;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{1'b0, MODE_FIXED, 3'b111, 3'b001, 12, "fixed_no_rotate"};
    tbl[1]  = '{1'b0, MODE_FIXED, 3'b000, 3'b000, 1,  "drop_to_idle"};
    tbl[2]  = '{1'b1, MODE_RR,    3'b111, 3'b001, 4,  "rr_hold_1"};
    tbl[3]  = '{1'b0, MODE_RR,    3'b111, 3'b010, 4,  "rr_hold_2"};
    tbl[4]  = '{1'b0, MODE_RR,    3'b111, 3'b100, 4,  "rr_hold_3"};
    tbl[5]  = '{1'b0, MODE_RR,    3'b111, 3'b001, 1,  "rr_wrap"};
    tbl[6]  = '{1'b0, MODE_RR,    3'b010, 3'b010, 1,  "rr_to_2"};
    tbl[7]  = '{1'b0, MODE_RR,    3'b101, 3'b100, 1,  "rr_drop_next"};
    tbl[8]  = '{1'b0, MODE_FIXED, 3'b010, 3'b010, 1,  "fixed_to_2"};
    tbl[9]  = '{1'b0, MODE_FIXED, 3'b101, 3'b001, 1,  "fixed_drop_low"};
    tbl[10] = '{1'b0, MODE_RR,    3'b001, 3'b001, 10, "rr_alone_hold"};
    tbl[11] = '{1'b0, MODE_RR,    3'b011, 3'b010, 1,  "rr_sat_rotate"};
    tbl[12] = '{1'b0, MODE_RR,    3'b100, 3'b100, 1,  "rr_to_3"};

    bus.rr_en = MODE_FIXED;
    bus.r     = 3'b111;
    model_reset();

    // Requests present while reset is held must not produce a grant.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check("in_reset", 3'b000);
    end
    #2 reset = 1'b0;
    apply(MODE_FIXED, 3'b001);
    check("first_grant", 3'b001);

    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) do_reset();
      for (int k = 0; k < tbl[i].reps; k++) begin
        apply(tbl[i].rr, tbl[i].r);
        check(tbl[i].nm, tbl[i].exp_g);
      end
    end

    // Reset between edges while g=100 clears at once; ptr restarts so r[2] wins over r[3].
    #2 reset = 1'b1;
    #1 check("async_clear", 3'b000);
    model_reset();
    #2 reset = 1'b0;
    apply(MODE_RR, 3'b110);
    check("post_reset_rr", 3'b010);

    for (int c = 0; c < 400; c++) begin
      logic       rr;
      logic [3:1] rv;
      if (c % 97 == 50) do_reset();
      rr = ($urandom_range(0, 9) < 7) ? MODE_RR : MODE_FIXED;
      rv = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      apply(rr, rv);
      check("random_vs_model", model_g());
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
